// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU control sequencer:
//   - MIPS-style function codes recognised by the decoder
//   - result-mux select encodings (SEL_ALU/SEL_SHT/SEL_HI/SEL_LO)
//   - FSM state encoding for the MULTU sequence (ST_IDLE/LOAD/MULT/WRITE)
//   - decoder result structure
// Optional feature macro used elsewhere in this slice: MULT_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  // Function codes (6-bit MIPS R-type funct field)
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Result mux selects
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_SHT = 2'd1;
  localparam logic [1:0] SEL_HI  = 2'd2;
  localparam logic [1:0] SEL_LO  = 2'd3;

  // MULTU sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_MULT  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // Decoder output bundle
  typedef struct packed {
    logic       is_multu;
    logic       legal;
    logic [1:0] mux_sel;
  } funct_dec_t;

  // Even parity over a function code, handy for downstream integrity checks
  function automatic logic funct_parity(input logic [5:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/alu_control_seq_if.sv
// -----------------------------------------------------------------------------
// alu_control_seq_if
// Bundles the function-code handshake and all control outputs of the
// ALU control sequencer.
//   master : function-code source / datapath side (drives funct_in, valid_in,
//            and mult_rem_zero when MULT_EARLY_EXIT_EN is defined)
//   slave  : the sequencer (alu_control_seq)
// Signals:
//   funct_in, valid_in, ready_out          handshake
//   SignaltoALU/SHT/MULTU, mux_sel         registered per-unit controls
//   mult_load, mult_step, hilo_we          multiplier strobes
//   iter_count, busy, done, illegal        status
//   mult_rem_zero                          only with MULT_EARLY_EXIT_EN
// -----------------------------------------------------------------------------
interface alu_control_seq_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNCT_WIDTH = 6
);
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  logic [FUNCT_WIDTH-1:0] funct_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [FUNCT_WIDTH-1:0] SignaltoALU;
  logic [FUNCT_WIDTH-1:0] SignaltoSHT;
  logic [FUNCT_WIDTH-1:0] SignaltoMULTU;
  logic [1:0]             mux_sel;
  logic                   mult_load;
  logic                   mult_step;
  logic                   hilo_we;
  logic [CNT_WIDTH-1:0]   iter_count;
  logic                   busy;
  logic                   done;
  logic                   illegal;
`ifdef MULT_EARLY_EXIT_EN
  logic                   mult_rem_zero;
`endif

  modport master (
`ifdef MULT_EARLY_EXIT_EN
    output mult_rem_zero,
`endif
    output funct_in, valid_in,
    input  ready_out, SignaltoALU, SignaltoSHT, SignaltoMULTU, mux_sel,
    input  mult_load, mult_step, hilo_we, iter_count, busy, done, illegal
  );

  modport slave (
`ifdef MULT_EARLY_EXIT_EN
    input  mult_rem_zero,
`endif
    input  funct_in, valid_in,
    output ready_out, SignaltoALU, SignaltoSHT, SignaltoMULTU, mux_sel,
    output mult_load, mult_step, hilo_we, iter_count, busy, done, illegal
  );

endinterface

// File: rtl/alu_control_seq_decode.sv
// -----------------------------------------------------------------------------
// alu_funct_decode
// Purely combinational function-code classifier.
// Ports:
//   funct  in   FUNCT_WIDTH  function code
//   dec    out  funct_dec_t  {is_multu, legal, mux_sel}
// Unknown codes report legal = 0 and is_multu = 0; mux_sel is then don't-care
// (driven to SEL_ALU) because the sequencer holds its previous select.
// -----------------------------------------------------------------------------
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6
) (
  input  logic [FUNCT_WIDTH-1:0] funct,
  output funct_dec_t             dec
);

  // Classify the function code
  always_comb begin
    dec.is_multu = 1'b0;
    dec.legal    = 1'b0;
    dec.mux_sel  = SEL_ALU;
    case (funct)
      FUNCT_WIDTH'(FN_AND),
      FUNCT_WIDTH'(FN_OR),
      FUNCT_WIDTH'(FN_ADD),
      FUNCT_WIDTH'(FN_SUB),
      FUNCT_WIDTH'(FN_SLT): begin
        dec.legal   = 1'b1;
        dec.mux_sel = SEL_ALU;
      end
      FUNCT_WIDTH'(FN_SRL): begin
        dec.legal   = 1'b1;
        dec.mux_sel = SEL_SHT;
      end
      FUNCT_WIDTH'(FN_MFHI): begin
        dec.legal   = 1'b1;
        dec.mux_sel = SEL_HI;
      end
      FUNCT_WIDTH'(FN_MFLO): begin
        dec.legal   = 1'b1;
        dec.mux_sel = SEL_LO;
      end
      FUNCT_WIDTH'(FN_MULTU): begin
        dec.legal    = 1'b1;
        dec.is_multu = 1'b1;
        dec.mux_sel  = SEL_ALU;
      end
      default: begin
        dec.is_multu = 1'b0;
        dec.legal    = 1'b0;
        dec.mux_sel  = SEL_ALU;
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
// Registers one function code per handshake into the ALU, shifter and
// multiplier control fields and the result mux select, and sequences the
// multi-cycle MULTU operation (LOAD, DATA_WIDTH shift-add steps, HI/LO write).
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    alu_control_seq_if.slave  handshake + control/status outputs
// Optional feature: MULT_EARLY_EXIT_EN -- when defined, bus.mult_rem_zero
// lets the MULT phase end as soon as the remaining multiplier bits are zero.
// Every output is a flop except ready_out, which is (state == IDLE).
// -----------------------------------------------------------------------------
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  alu_control_seq_if.slave    bus
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DATA_WIDTH - 1);

  funct_dec_t dec_s;

  logic [1:0]             state_r, state_nxt;
  logic [FUNCT_WIDTH-1:0] alu_r, sht_r, mul_r;
  logic [FUNCT_WIDTH-1:0] code_nxt;
  logic [1:0]             sel_r, sel_nxt;
  logic                   load_r, load_nxt;
  logic                   step_r, step_nxt;
  logic                   we_r, we_nxt;
  logic [CNT_WIDTH-1:0]   iter_r, iter_nxt;
  logic                   busy_r, busy_nxt;
  logic                   done_r, done_nxt;
  logic                   illegal_r, illegal_nxt;
  logic                   accept_s;
  logic                   exit_mult_s;

  alu_funct_decode #(
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_decode (
    .funct (bus.funct_in),
    .dec   (dec_s)
  );

  assign accept_s = bus.valid_in && (state_r == ST_IDLE);

  // Decide whether the step finishing at this edge is the final one
`ifdef MULT_EARLY_EXIT_EN
  assign exit_mult_s = (iter_r == LAST_STEP) || bus.mult_rem_zero;
`else
  assign exit_mult_s = (iter_r == LAST_STEP);
`endif

  // Next-state and next-output computation
  always_comb begin
    state_nxt   = state_r;
    code_nxt    = alu_r;
    sel_nxt     = sel_r;
    load_nxt    = 1'b0;
    step_nxt    = 1'b0;
    we_nxt      = 1'b0;
    iter_nxt    = iter_r;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (dec_s.is_multu) begin
            // mux_sel deliberately holds: the MULTU itself produces no result
            code_nxt  = bus.funct_in;
            state_nxt = ST_LOAD;
            load_nxt  = 1'b1;
            busy_nxt  = 1'b1;
            iter_nxt  = '0;
          end else if (dec_s.legal) begin
            code_nxt  = bus.funct_in;
            sel_nxt   = dec_s.mux_sel;
            done_nxt  = 1'b1;
          end else begin
            illegal_nxt = 1'b1;
            done_nxt    = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_MULT;
        step_nxt  = 1'b1;
      end
      ST_MULT: begin
        // every MULT cycle carries a step, so each edge here completes one
        iter_nxt = iter_r + CNT_WIDTH'(1);
        if (exit_mult_s) begin
          state_nxt = ST_WRITE;
          we_nxt    = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_MULT;
          step_nxt  = 1'b1;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      alu_r     <= '0;
      sht_r     <= '0;
      mul_r     <= '0;
      sel_r     <= SEL_ALU;
      load_r    <= 1'b0;
      step_r    <= 1'b0;
      we_r      <= 1'b0;
      iter_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      alu_r     <= code_nxt;
      sht_r     <= code_nxt;
      mul_r     <= code_nxt;
      sel_r     <= sel_nxt;
      load_r    <= load_nxt;
      step_r    <= step_nxt;
      we_r      <= we_nxt;
      iter_r    <= iter_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      illegal_r <= illegal_nxt;
    end
  end

  assign bus.ready_out     = (state_r == ST_IDLE);
  assign bus.SignaltoALU   = alu_r;
  assign bus.SignaltoSHT   = sht_r;
  assign bus.SignaltoMULTU = mul_r;
  assign bus.mux_sel       = sel_r;
  assign bus.mult_load     = load_r;
  assign bus.mult_step     = step_r;
  assign bus.hilo_we       = we_r;
  assign bus.iter_count    = iter_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.illegal       = illegal_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: directed scenarios plus random
// traffic, compared every cycle against a cycle-offset reference model.
module tb_alu_control_seq;

  localparam int DW = 32;
`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [5:0] REF_CODE [9] = '{6'b100100, 6'b100101, 6'b100000,
    6'b100010, 6'b101010, 6'b000010, 6'b011001, 6'b010000, 6'b010010};
  // 0..3 = mux select of a single-cycle op, 4 = MULTU
  localparam int REF_KIND [9] = '{0, 0, 0, 0, 0, 1, 4, 2, 3};

  logic clk;
  logic reset;
  logic rz_drv;
  int   n_chk;
  int   n_fail;

  alu_control_seq_if #(.DATA_WIDTH(DW), .FUNCT_WIDTH(6)) bus ();

`ifdef MULT_EARLY_EXIT_EN
  assign bus.mult_rem_zero = rz_drv;
`endif

  alu_control_seq #(.DATA_WIDTH(DW), .FUNCT_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_kind(input logic [5:0] f);
    for (int i = 0; i < 9; i++) begin
      if (f == REF_CODE[i]) return REF_KIND[i];
    end
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int e_alu, e_sel, e_load, e_step, e_we, e_iter, e_busy, e_done, e_ill, e_ready;
  bit m_act, m_wr;
  int mk;  // number of step cycles begun since the MULTU accept (0 = load cycle)

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_alu <= 0; e_sel <= 0; e_load <= 0; e_step <= 0; e_we <= 0;
      e_iter <= 0; e_busy <= 0; e_done <= 0; e_ill <= 0; e_ready <= 1;
      m_act <= 1'b0; m_wr <= 1'b0; mk <= 0;
    end else begin
      e_load <= 0; e_step <= 0; e_we <= 0; e_done <= 0; e_ill <= 0;
      if (!m_act) begin
        if (bus.valid_in) begin
          if (ref_kind(bus.funct_in) == 4) begin
            e_alu <= int'(bus.funct_in); e_busy <= 1; e_ready <= 0;
            e_iter <= 0; e_load <= 1; m_act <= 1'b1; mk <= 0;
          end else if (ref_kind(bus.funct_in) >= 0) begin
            e_alu <= int'(bus.funct_in); e_sel <= ref_kind(bus.funct_in);
            e_done <= 1;
          end else begin
            e_ill <= 1; e_done <= 1;
          end
        end
      end else if (m_wr) begin
        m_act <= 1'b0; m_wr <= 1'b0; e_busy <= 0; e_ready <= 1;
      end else if (mk == 0) begin
        e_step <= 1; mk <= 1;
      end else begin
        e_iter <= mk;
        if (mk == DW || (EARLY && rz_drv)) begin
          e_we <= 1; e_done <= 1; m_wr <= 1'b1;
        end else begin
          e_step <= 1; mk <= mk + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ready_out", 32'(bus.ready_out), e_ready);
    chk("SignaltoALU", 32'(bus.SignaltoALU), e_alu);
    chk("SignaltoSHT", 32'(bus.SignaltoSHT), e_alu);
    chk("SignaltoMULTU", 32'(bus.SignaltoMULTU), e_alu);
    chk("mux_sel", 32'(bus.mux_sel), e_sel);
    chk("mult_load", 32'(bus.mult_load), e_load);
    chk("mult_step", 32'(bus.mult_step), e_step);
    chk("hilo_we", 32'(bus.hilo_we), e_we);
    chk("iter_count", 32'(bus.iter_count), e_iter);
    chk("busy", 32'(bus.busy), e_busy);
    chk("done", 32'(bus.done), e_done);
    chk("illegal", 32'(bus.illegal), e_ill);
  endtask

  task automatic drive(input logic [5:0] f, input logic v);
    bus.funct_in = f;
    bus.valid_in = v;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int steps, we_at;
    bit found;
    n_chk = 0; n_fail = 0;
    rz_drv = 1'b0;
    reset = 1'b1;
    drive(6'b000000, 1'b0);
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_ready", 32'(bus.ready_out), 32'd1);
    chk("rst_alu", 32'(bus.SignaltoALU), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // ADD
    drive(6'b100000, 1'b1);
    cyc();
    chk("add_alu", 32'(bus.SignaltoALU), 32'b100000);
    chk("add_sel", 32'(bus.mux_sel), 32'd0);
    chk("add_done", 32'(bus.done), 32'd1);
    chk("add_ready", 32'(bus.ready_out), 32'd1);
    drive(6'b000010, 1'b1);  // SRL back-to-back
    cyc();
    chk("srl_sel", 32'(bus.mux_sel), 32'd1);
    chk("srl_done", 32'(bus.done), 32'd1);
    drive(6'b010000, 1'b1);  // MFHI
    cyc();
    chk("mfhi_sel", 32'(bus.mux_sel), 32'd2);
    chk("mfhi_done", 32'(bus.done), 32'd1);
    drive(6'b010010, 1'b1);  // MFLO
    cyc();
    chk("mflo_sel", 32'(bus.mux_sel), 32'd3);
    chk("mflo_done", 32'(bus.done), 32'd1);
    drive(6'b000000, 1'b0);
    cyc();
    chk("done_drop", 32'(bus.done), 32'd0);

    // MULTU with ADD held on valid_in throughout
    drive(6'b011001, 1'b1);
    cyc();
    chk("mul_load_e1", 32'(bus.mult_load), 32'd1);
    chk("mul_ready_e1", 32'(bus.ready_out), 32'd0);
    chk("mul_sel_hold", 32'(bus.mux_sel), 32'd3);
    drive(6'b100000, 1'b1);
    steps = 0; we_at = 0;
    for (int c = 2; c <= 45 && we_at == 0; c++) begin
      cyc();
      if (bus.mult_step) steps++;
      if (bus.hilo_we) begin
        we_at = c;
        chk("mul_iter_final", 32'(bus.iter_count), 32'd32);
        chk("mul_done", 32'(bus.done), 32'd1);
        chk("mul_code_kept", 32'(bus.SignaltoALU), 32'b011001);
      end
    end
    chk("mul_step_count", steps, 32'd32);
    chk("mul_we_offset", we_at, 32'd34);
    cyc();
    chk("mul_ready_back", 32'(bus.ready_out), 32'd1);
    chk("mul_add_ignored", 32'(bus.SignaltoALU), 32'b011001);
    chk("mul_iter_hold", 32'(bus.iter_count), 32'd32);
    cyc();
    chk("add_after_mul", 32'(bus.SignaltoALU), 32'b100000);
    drive(6'b111111, 1'b1);  // illegal
    cyc();
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    chk("ill_done", 32'(bus.done), 32'd1);
    chk("ill_hold", 32'(bus.SignaltoALU), 32'b100000);
    drive(6'b000000, 1'b0);
    cyc();
    chk("ill_drop", 32'(bus.illegal), 32'd0);

    // reset during MULT at iter_count = 17
    drive(6'b011001, 1'b1);
    cyc();
    drive(6'b000000, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cyc();
      if (bus.iter_count == 17) found = 1'b1;
    end
    chk("mid_reach17", 32'(bus.iter_count), 32'd17);
    reset = 1'b1;
    #1;
    compare_all();
    chk("mid_alu0", 32'(bus.SignaltoALU), 32'd0);
    chk("mid_iter0", 32'(bus.iter_count), 32'd0);
    chk("mid_busy0", 32'(bus.busy), 32'd0);
    chk("mid_step0", 32'(bus.mult_step), 32'd0);
    chk("mid_ready1", 32'(bus.ready_out), 32'd1);
    cyc();
    chk("mid_no_we", 32'(bus.hilo_we), 32'd0);
    chk("mid_no_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    drive(6'b100100, 1'b1);
    cyc();
    chk("and_after_rst", 32'(bus.SignaltoALU), 32'b100100);
    chk("and_done", 32'(bus.done), 32'd1);
    drive(6'b000000, 1'b0);
    cyc();

`ifdef MULT_EARLY_EXIT_EN
    drive(6'b011001, 1'b1);
    cyc();
    drive(6'b000000, 1'b0);
    we_at = 0;
    for (int c = 2; c <= 45 && we_at == 0; c++) begin
      cyc();
      if (bus.hilo_we) begin
        we_at = c;
        chk("early_iter", 32'(bus.iter_count), 32'd5);
      end
      rz_drv = (bus.mult_step && bus.iter_count == 4) ? 1'b1 : 1'b0;
    end
    rz_drv = 1'b0;
    chk("early_we_offset", we_at, 32'd7);
    cyc();
    cyc();
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      r = int'($urandom_range(0, 15));
      if (r == 0) bus.funct_in = 6'b011001;
      else if (r == 1) bus.funct_in = 6'($urandom_range(0, 63));
      else bus.funct_in = REF_CODE[$urandom_range(0, 8) == 6 ? 0 : $urandom_range(0, 8)];
      bus.valid_in = ($urandom_range(0, 3) != 0);
      rz_drv = EARLY ? ($urandom_range(0, 15) == 0) : 1'b0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
